// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, IF/ID register and IDLE/FETCH/HALT control
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_op,
    output logic [5:0]  id_func
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_fetch;
    logic        halt_cond;
    logic        xfer;

    assign in_fetch  = (state == FETCH);
    assign halt_cond = in_fetch & id_valid & halt;
    assign xfer      = in_fetch & imem_ready & ~stall & ~redirect & ~flush & ~halt_cond;
    assign pc_plus4  = pc + 32'd4;

    assign imem_req  = in_fetch;
    assign imem_addr = pc;
    assign id_op     = id_instr[31:26];
    assign id_func   = id_instr[5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (halt_cond) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Priority: halt > redirect > flush > stall > transfer/bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_instr <= 32'd0;
            id_pc    <= 32'd0;
            id_pc4   <= 32'd0;
        end else if (in_fetch) begin
            if (halt_cond) begin
                id_valid <= 1'b0;
            end else if (redirect) begin
                pc       <= redirect_pc & 32'hFFFF_FFFC;
                id_valid <= 1'b0;
            end else if (flush) begin
                id_valid <= 1'b0;
            end else if (!stall) begin
                if (imem_ready) begin
                    id_instr <= imem_rdata;
                    id_pc    <= pc;
                    id_pc4   <= pc_plus4;
                    id_valid <= 1'b1;
                    pc       <= pc_plus4;
                end else begin
                    id_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (xfer && fetch_cnt != 32'hFFFF_FFFF) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (in_fetch && !xfer && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
